// File: rtl/prim_elasticbuf_pkg.sv
// Shared helpers for the elastic buffer.
// Holds only functions, so the buffer's pointer and count widths stay local to the buffer itself.
package prim_elasticbuf_pkg;

  // Modulo-depth increment.
  // It works for any depth, not only powers of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/prim_elasticbuf.sv
// Elastic FIFO buffer with registered ready/valid.
// Both handshake outputs come from flops, so there are no combinational paths through the buffer.
module prim_elasticbuf
  import prim_elasticbuf_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned ZERO_ON_INVALID = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  output logic                       urdy_o,
  input  logic                       uvld_i,
  input  logic [WIDTH-1:0]           udat_i,
  input  logic                       drdy_i,
  output logic                       dvld_o,
  output logic [WIDTH-1:0]           ddat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             urdy_q, dvld_q, written_q;
  logic             up_beat, dn_beat;

  assign up_beat = uvld_i & urdy_q;
  assign dn_beat = dvld_q & drdy_i;

  // Flush overrides both beats.
  // Any upstream word offered in the flush cycle is simply lost.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (up_beat) wptr_d = PTR_W'(wrap_inc(32'(wptr_q), DEPTH));
      if (dn_beat) rptr_d = PTR_W'(wrap_inc(32'(rptr_q), DEPTH));
      unique case ({up_beat, dn_beat})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      urdy_q    <= 1'b0;
      dvld_q    <= 1'b0;
      written_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      urdy_q    <= (count_d < FULL_CNT);
      dvld_q    <= (count_d != '0);
      written_q <= written_q | (up_beat & ~flush_i);
    end
  end

  always_ff @(posedge clk) begin
    if (up_beat && !flush_i) mem[wptr_q] <= udat_i;
  end

  // The storage array has no reset.
  // Until the first write, the output is masked so that reset drives zeros rather than X.
  always_comb begin
    ddat_o = mem[rptr_q];
    if (!written_q || ((ZERO_ON_INVALID != 0) && !dvld_q)) ddat_o = '0;
  end

  assign urdy_o  = urdy_q;
  assign dvld_o  = dvld_q;
  assign count_o = count_q;

`ifndef SYNTHESIS
  event up_beat_ev;
  event dn_beat_ev;

  always @(posedge clk) begin
    if (reset_n && !flush_i && up_beat) -> up_beat_ev;
    if (reset_n && !flush_i && dn_beat) -> dn_beat_ev;
    if (reset_n) begin
      assert (count_q <= FULL_CNT);
      assert (32'(wptr_q) < DEPTH && 32'(rptr_q) < DEPTH);
      assert (!(up_beat && count_q == FULL_CNT));
    end
  end
`endif

endmodule

// File: tb/tb_prim_elasticbuf.sv
// Self-checking bench for prim_elasticbuf.
// Three instances (DEPTH 2, DEPTH 3, and DEPTH 5 with zeroing) are checked against a queue-style reference model.
module tb_prim_elasticbuf;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush [N];
  logic        uvld  [N];
  logic        drdy  [N];
  logic        urdy  [N];
  logic        dvld  [N];
  logic [31:0] udat  [N];
  logic [31:0] ddat  [N];
  logic [1:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;

  logic [31:0] mbuf  [N][16];
  int          mhead [N];
  int          mtail [N];
  bit          mrdy  [N];
  bit          mup   [N];
  bit          in_reset;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prim_elasticbuf #(.WIDTH(32), .DEPTH(2), .ZERO_ON_INVALID(0)) u_d2 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush[0]), .urdy_o(urdy[0]),
    .uvld_i(uvld[0]), .udat_i(udat[0]), .drdy_i(drdy[0]), .dvld_o(dvld[0]),
    .ddat_o(ddat[0]), .count_o(cnt_a)
  );

  prim_elasticbuf #(.WIDTH(32), .DEPTH(3), .ZERO_ON_INVALID(0)) u_d3 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush[1]), .urdy_o(urdy[1]),
    .uvld_i(uvld[1]), .udat_i(udat[1]), .drdy_i(drdy[1]), .dvld_o(dvld[1]),
    .ddat_o(ddat[1]), .count_o(cnt_b)
  );

  prim_elasticbuf #(.WIDTH(32), .DEPTH(5), .ZERO_ON_INVALID(1)) u_d5 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush[2]), .urdy_o(urdy[2]),
    .uvld_i(uvld[2]), .udat_i(udat[2]), .drdy_i(drdy[2]), .dvld_o(dvld[2]),
    .ddat_o(ddat[2]), .count_o(cnt_c)
  );

  function automatic int dep_of(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic logic [2:0] obs_cnt(input int i);
    case (i)
      0:       return {1'b0, cnt_a};
      1:       return {1'b0, cnt_b};
      default: return cnt_c;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mhead[i] = 0;
      mtail[i] = 0;
      mrdy[i]  = 1'b0;
      mup[i]   = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input int i, input logic v, input logic [31:0] d,
                                input logic r, input logic f);
    uvld[i]  = v;
    udat[i]  = d;
    drdy[i]  = r;
    flush[i] = f;
  endtask

  task automatic check_output(input int i);
    int          sz;
    logic        exp_vld;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_dat;
    sz      = mtail[i] - mhead[i];
    exp_vld = (sz != 0);
    exp_cnt = 3'(sz);
    checks++;
    assert (dvld[i] === exp_vld) else begin
      errors++;
      $error("[TB] FAIL dvld[%0d] observed=%0b expected=%0b", i, dvld[i], exp_vld);
    end
    checks++;
    assert (urdy[i] === mrdy[i]) else begin
      errors++;
      $error("[TB] FAIL urdy[%0d] observed=%0b expected=%0b", i, urdy[i], mrdy[i]);
    end
    checks++;
    assert (obs_cnt(i) === exp_cnt) else begin
      errors++;
      $error("[TB] FAIL count[%0d] observed=%0d expected=%0d", i, obs_cnt(i), exp_cnt);
    end
    if (sz != 0 || i == 2 || in_reset) begin
      exp_dat = (sz != 0) ? mbuf[i][mhead[i] % 16] : 32'h0;
      checks++;
      assert (ddat[i] === exp_dat) else begin
        errors++;
        $error("[TB] FAIL ddat[%0d] observed=%08h expected=%08h", i, ddat[i], exp_dat);
      end
    end
  endtask

  // One clock edge: advance the reference model, then sample all DUTs on the falling edge.
  task automatic tick();
    int sz;
    bit dn;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      sz     = mtail[i] - mhead[i];
      mup[i] = uvld[i] && mrdy[i] && !flush[i];
      dn     = (sz != 0) && drdy[i];
      if (flush[i]) begin
        mhead[i] = mtail[i];
      end else begin
        if (dn) mhead[i]++;
        if (mup[i]) begin
          mbuf[i][mtail[i] % 16] = udat[i];
          mtail[i]++;
        end
      end
      mrdy[i] = (mtail[i] - mhead[i]) < dep_of(i);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) check_output(i);
  endtask

  initial begin
    logic [31:0] words [4];
    int          k;
    words[0] = 32'hA;
    words[1] = 32'hB;
    words[2] = 32'hC;
    words[3] = 32'hD;

    reset_n  = 1'b0;
    in_reset = 1'b1;
    for (int i = 0; i < N; i++) apply_stimulus(i, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    model_reset();

    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) check_output(i);
    end
    reset_n  = 1'b1;
    in_reset = 1'b0;
    tick();
    repeat (3) tick();

    $display("[TB] streaming 16 words through DEPTH=2");
    for (int v = 1; v <= 16; v++) begin
      apply_stimulus(0, 1'b1, 32'(v), 1'b1, 1'b0);
      tick();
    end
    apply_stimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) tick();

    $display("[TB] fill and stall on DEPTH=3");
    k = 0;
    for (int c = 0; c < 14; c++) begin
      apply_stimulus(1, (k < 4), (k < 4) ? words[k] : 32'h0, (c >= 6), 1'b0);
      tick();
      if (mup[1]) k++;
    end

    $display("[TB] flush with simultaneous upstream word");
    apply_stimulus(1, 1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    apply_stimulus(1, 1'b1, 32'h22, 1'b0, 1'b0);
    tick();
    apply_stimulus(1, 1'b1, 32'hBAD, 1'b0, 1'b1);
    tick();
    apply_stimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) tick();

    $display("[TB] random traffic on DEPTH=5");
    for (int c = 0; c < 10000; c++) begin
      apply_stimulus(2, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end
    apply_stimulus(2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    repeat (6) tick();

    $display("[TB] reset in the middle of a transfer");
    apply_stimulus(0, 1'b1, 32'h55, 1'b0, 1'b0);
    apply_stimulus(2, 1'b1, 32'h66, 1'b0, 1'b0);
    repeat (2) tick();
    reset_n  = 1'b0;
    in_reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) check_output(i);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_output(i);
    for (int i = 0; i < N; i++) apply_stimulus(i, 1'b0, 32'h0, 1'b1, 1'b0);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prim_elasticbuf.md
PRIM_ELASTICBUF -- requirements
Module: prim_elasticbuf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning payload bit width (legal values 1 or more).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning number of storage entries (legal values 2 or more; 2 gives a full-throughput registered-ready skid pair).
REQ-003 The block SHALL have parameter ZERO_ON_INVALID, default 0, meaning that when it is 1, ddat_o is forced to all-zero whenever dvld_o is 0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous discard of all stored entries.
REQ-007 The block SHALL have port urdy_o, output, 1 bit: upstream ready, driven directly from a flop with no combinational path from any input.
REQ-008 The block SHALL have port uvld_i, input, 1 bit: upstream valid.
REQ-009 The block SHALL have port udat_i, input, WIDTH bits: upstream payload.
REQ-010 The block SHALL have port drdy_i, input, 1 bit: downstream ready.
REQ-011 The block SHALL have port dvld_o, output, 1 bit: downstream valid, flop-driven.
REQ-012 The block SHALL have port ddat_o, output, WIDTH bits: downstream payload, the head entry.
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH+1) bits: current occupancy, flop-driven.

Function
REQ-014 The block SHALL treat an upstream beat as the cycle in which uvld_i and urdy_o are both 1, and a downstream beat as the cycle in which dvld_o and drdy_i are both 1.
REQ-015 The block SHALL deliver entries in FIFO order, with no loss and no duplication.
REQ-016 The block SHALL have 1-cycle latency: data accepted at edge N is visible on dvld_o/ddat_o after edge N when the buffer was empty.
REQ-017 The block SHALL update the occupancy count as +1 on an upstream beat only, -1 on a downstream beat only, and unchanged on both or neither.
REQ-018 The block SHALL set urdy_o to the registered value of (next count < DEPTH), so that full means urdy_o=0 the following cycle regardless of drdy_i.
REQ-019 The block SHALL set dvld_o to the registered value of (next count != 0).
REQ-020 The block SHALL sustain one beat per cycle in steady state (count between 1 and DEPTH-1 with both sides active) without any bubble.
REQ-021 The block SHALL, when full with drdy_i=1, pop one entry and present urdy_o=1 in the next cycle; no upstream beat is possible in the full cycle itself.
REQ-022 The block SHALL let the read and write pointers wrap modulo DEPTH, including DEPTH values that are not a power of two; the pointers SHALL never index beyond DEPTH-1.
REQ-023 The block SHALL hold ddat_o stable while dvld_o=1 and drdy_i=0.
REQ-024 The block SHALL give flush_i priority over beats: at the next edge the count goes to 0, pointers to 0, dvld_o to 0 and urdy_o to 1, and any simultaneous upstream beat is dropped.
REQ-025 The block SHALL, when ZERO_ON_INVALID is 1, output ddat_o=0 whenever dvld_o=0; otherwise ddat_o is don't-care when dvld_o=0.
REQ-026 The block SHALL never write storage when no upstream beat occurs.

Reset
REQ-027 The block SHALL, while reset_n=0, asynchronously force count_o=0, dvld_o=0, urdy_o=0, pointers=0 and ddat_o=0.
REQ-028 The block SHALL raise urdy_o to 1 on the first clk edge after reset_n deasserts, with no beat accepted before then.
REQ-029 The block SHALL treat reset asserted mid-transfer as discarding all contents, with no partial beat delivered afterwards.
REQ-030 The block SHALL leave the storage array unreset.

Structure
REQ-031 The block SHALL compute pointer and count widths locally from DEPTH, with no new typedefs added to the shared prim package.
REQ-032 The block SHALL implement storage inline as a register array, with no sub-module.
REQ-033 The block SHALL provide simulation-only events for upstream and downstream beats, matching existing prim blocks.

Verification
REQ-034 The bench SHALL cover reset release: hold reset_n=0 for 3 cycles, then release -> urdy_o=0 and dvld_o=0 during reset; urdy_o=1 one edge after release; count_o=0.
REQ-035 The bench SHALL cover streaming: DEPTH=2, push 0x1..0x10 every cycle with drdy_i=1 -> 16 outputs in order, 1-cycle latency, no bubbles, count_o stays 1.
REQ-036 The bench SHALL cover fill and stall: DEPTH=3, drdy_i=0, push 0xA,0xB,0xC,0xD -> urdy_o=0 after the 3rd beat, 0xD held upstream, count_o=3; then drdy_i=1 -> output A,B,C,D, with urdy_o=1 one cycle after the first pop.
REQ-037 The bench SHALL cover flush: count_o=2 and flush_i=1 with a simultaneous upstream beat -> next cycle count_o=0, dvld_o=0, urdy_o=1, and the dropped word never appears.
REQ-038 The bench SHALL cover ZERO_ON_INVALID=1: idle with udat_i=0xFFFFFFFF and uvld_i=0 -> ddat_o=0 throughout.
REQ-039 The bench SHALL run a random test on DEPTH=5, with random uvld_i and drdy_i over 10k cycles against a scoreboard -> ordering, count_o and no-overflow assertions all hold.
